// File: rtl/reg_dump_reader_if.sv
// Bundle of the register-dump command, regFile read port and output stream.
// slave: the dump engine; master: whoever issues commands and consumes words.
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              abort;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  modport slave (
    input  start, first_addr, last_addr, abort, rf_data, out_ready,
    output rf_addr, out_valid, out_data, out_addr, busy, done
  );

  modport master (
    output start, first_addr, last_addr, abort, rf_data, out_ready,
    input  rf_addr, out_valid, out_data, out_addr, busy, done
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a (wrapping) register range through one regFile
// read port and streams each word with its address over valid/ready.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  reg_dump_reader_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q,   cur_d;
  logic [ADDR_W-1:0] end_q,   end_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // abort wins over start and out_ready; it leaves the range registers untouched
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            cur_d   = bus.first_addr;
            end_d   = bus.last_addr;
            state_d = FETCH;
          end
        end
        FETCH: begin
          data_d  = bus.rf_data;
          addr_d  = cur_q;
          state_d = SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            if (cur_q == end_q) begin
              state_d = DONE;
            end else begin
              cur_d   = cur_q + ADDR_W'(1);
              state_d = FETCH;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // all outputs decode from registers only, so out_ready never reaches out_valid
  assign bus.rf_addr   = cur_q;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.busy      = (state_q == FETCH) || (state_q == SEND);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: stimulus pushes expected words, a
// negedge monitor compares every presented word against the queue head.
module tb_reg_dump_reader;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] rf [32];
  logic [31:0] shadow [32];

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;
  int   done_seen;
  int   exp_done;

  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) rf[wa] <= wd;
  end
  assign bus.rf_data = rf[bus.rf_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compare whatever the DUT presents; pop only when the handshake completes
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) done_seen++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got addr %0d data %0h, expected no word", bus.out_addr, bus.out_data);
        end else begin
          check("word_addr", 32'(bus.out_addr), 32'(exp_q[0].a));
          check("word_data", bus.out_data, exp_q[0].d);
          if (bus.out_ready && !bus.abort) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issues start for one cycle and pushes the expected words; returns in the FETCH cycle
  task automatic do_start(input logic [4:0] first, input logic [4:0] last);
    logic [4:0] diff;
    logic [4:0] a;
    exp_t e;
    diff = last - first;
    for (int i = 0; i <= int'(diff); i++) begin
      a = first + 5'(i);
      e.a = a;
      e.d = shadow[a];
      exp_q.push_back(e);
    end
    bus.start      = 1'b1;
    bus.first_addr = first;
    bus.last_addr  = last;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    if (bus.done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected done", name, limit);
    end else begin
      exp_done++;
    end
    tick();
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_busy"},  32'(bus.busy),      32'd0);
    check({name, "_done"},  32'(bus.done),      32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_seen = 0; exp_done = 0;
    rst = 1'b0;
    we = 1'b0; wa = '0; wd = '0;
    bus.start = 1'b0; bus.first_addr = '0; bus.last_addr = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b1;
    repeat (2) tick();

    check_idle_outputs("reset");
    check("reset_rf_addr",  32'(bus.rf_addr),  32'd0);
    check("reset_out_data", bus.out_data,      32'd0);
    check("reset_out_addr", 32'(bus.out_addr), 32'd0);
    rst = 1'b1;

    // preload the whole register file through the write port
    for (int i = 0; i < 32; i++) begin
      shadow[i] = 32'h1000 + 32'(i);
    end
    shadow[5] = 32'hDEADBEEF; shadow[6] = 32'd1; shadow[7] = 32'd2;
    shadow[30] = 32'd30; shadow[31] = 32'd31; shadow[0] = 32'd0; shadow[1] = 32'd1;
    shadow[9] = 32'h11;
    we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wa = 5'(i);
      wd = shadow[i];
      tick();
    end
    we = 1'b0;
    tick();

    // 1: range 5..7, exact cycle timing
    do_start(5'd5, 5'd7);
    check("t1_n1_valid",   32'(bus.out_valid), 32'd0);
    check("t1_n1_busy",    32'(bus.busy),      32'd1);
    check("t1_n1_rf_addr", 32'(bus.rf_addr),   32'd5);
    for (int k = 2; k <= 8; k++) begin
      tick();
      check($sformatf("t1_n%0d_valid", k), 32'(bus.out_valid), (k == 2 || k == 4 || k == 6) ? 32'd1 : 32'd0);
      check($sformatf("t1_n%0d_done", k),  32'(bus.done),      (k == 7) ? 32'd1 : 32'd0);
      check($sformatf("t1_n%0d_busy", k),  32'(bus.busy),      (k <= 6) ? 32'd1 : 32'd0);
    end
    exp_done++;
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: wrapping range 30..1
    do_start(5'd30, 5'd1);
    wait_done("t2", 40);

    // 3: backpressure on word 2 for 5 cycles
    do_start(5'd5, 5'd7);
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t3_stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    wait_done("t3", 40);

    // 4: write to r9 on its FETCH edge is not visible; a second dump sees it
    do_start(5'd9, 5'd9);
    we = 1'b1; wa = 5'd9; wd = 32'h55;
    tick();
    we = 1'b0;
    shadow[9] = 32'h55;
    wait_done("t4a", 20);
    do_start(5'd9, 5'd9);
    wait_done("t4b", 20);

    // 5: abort during SEND of word 2 of a full 0..31 dump
    do_start(5'd0, 5'd31);
    tick();
    tick();
    tick();
    check("t5_pre_abort_valid", 32'(bus.out_valid), 32'd1);
    check("t5_pre_abort_addr",  32'(bus.out_addr),  32'd1);
    bus.abort = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.delete();
    check_idle_outputs("t5_after_abort");
    repeat (4) begin
      tick();
      check_idle_outputs("t5_idle");
    end
    do_start(5'd30, 5'd1);
    wait_done("t5_fresh", 40);

    // 6a: asynchronous reset mid-dump
    do_start(5'd0, 5'd31);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    check("t6_rst_rf_addr",  32'(bus.rf_addr),  32'd0);
    check("t6_rst_out_data", bus.out_data,      32'd0);
    check("t6_rst_out_addr", 32'(bus.out_addr), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("t6_post_rst");

    // 6b: start while busy changes neither range nor word count
    do_start(5'd5, 5'd7);
    tick();
    bus.start = 1'b1; bus.first_addr = 5'd0; bus.last_addr = 5'd31;
    tick();
    bus.start = 1'b0;
    wait_done("t6b", 40);
    repeat (4) begin
      tick();
      check_idle_outputs("t6b_idle");
    end

    check("done_count", 32'(done_seen), 32'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule
